// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load port.
// Emits one bit per cycle, with back-to-back words and no gap between them.
module piso_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             last_q, last_d;
    logic             at_end;
    logic             accept;

    // Load window: idle, or the final bit of the word in flight.
    always_comb begin
        at_end    = (state_q == S_SHIFT) && (cnt_q == CNT_MAX);
        din_ready = rst && ((state_q == S_IDLE) || at_end);
        accept    = din_valid && din_ready;
    end

    // Next state: load a new word, advance one bit, or fall back to idle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        sout_d       = IDLE_BIT;
        sout_valid_d = 1'b0;
        last_d       = 1'b0;
        if (accept) begin
            state_d      = S_SHIFT;
            cnt_d        = '0;
            shreg_d      = din;
            sout_d       = MSB_FIRST ? din[WIDTH-1] : din[0];
            sout_valid_d = 1'b1;
        end else if (state_q == S_SHIFT) begin
            if (at_end) begin
                state_d = S_IDLE;
            end else begin
                cnt_d        = cnt_q + CW'(1);
                sout_valid_d = 1'b1;
                last_d       = (cnt_d == CNT_MAX);
                if (MSB_FIRST) begin
                    shreg_d = shreg_q << 1;
                    sout_d  = shreg_q[WIDTH-2];
                end else begin
                    shreg_d = shreg_q >> 1;
                    sout_d  = shreg_q[1];
                end
            end
        end
    end

    // Registers, with a synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_q       <= last_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign last       = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances
// share one stimulus stream; a small 1010 detector watches the serial output.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, sout, sout_valid, last;
    logic       din_ready2, sout2, sout_valid2, last2;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit det_en = 1'b0;
    logic [2:0] hist = '0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
        .last(last)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready2), .sout(sout2), .sout_valid(sout_valid2),
        .last(last2)
    );

    // Non-overlapping 1010 detector fed by the MSB-first stream.
    always @(posedge clk) begin
        if (!det_en) begin
            hist <= '0;
        end else if (sout_valid) begin
            if ({hist, sout} == 4'b1010) begin
                pulses <= pulses + 1;
                hist   <= '0;
            end else begin
                hist <= {hist[1:0], sout};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check one full word on both instances, starting the cycle after H.
    task automatic shift_word(input logic [7:0] w, input int chg_at,
                              input logic [7:0] chg_din, input bit drop);
        for (int i = 0; i < 8; i++) begin
            chk("msb_sout", sout, w[7-i]);
            chk("lsb_sout", sout2, w[i]);
            chk("sout_valid", sout_valid, 1'b1);
            chk("lsb_valid", sout_valid2, 1'b1);
            chk("last", last, i == 7);
            chk("lsb_last", last2, i == 7);
            chk("din_ready", din_ready, i == 7);
            chk("lsb_ready", din_ready2, i == 7);
            if (i == chg_at) din = chg_din;
            if (i == 7 && drop) din_valid = 1'b0;
            tick();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sout"}, sout, 1'b0);
        chk({tag, "_valid"}, sout_valid, 1'b0);
        chk({tag, "_last"}, last, 1'b0);
        chk({tag, "_ready"}, din_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        tick();
        tick();
        chk("rst_sout", sout, 1'b0);
        chk("rst_valid", sout_valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_ready", din_ready, 1'b0);

        din       = 8'hFF;
        din_valid = 1'b1;
        tick();
        chk("rst_no_hs_valid", sout_valid, 1'b0);
        chk("rst_no_hs_ready", din_ready, 1'b0);

        din_valid = 1'b0;
        rst       = 1'b1;
        tick();
        chk_idle("idle");

        // Single word A5
        din       = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        shift_word(8'hA5, -1, 8'h00, 1'b1);
        chk_idle("a5_after");

        // Back-to-back A0 then 5A
        din       = 8'hA0;
        din_valid = 1'b1;
        tick();
        din = 8'h5A;
        shift_word(8'hA0, -1, 8'h00, 1'b0);
        shift_word(8'h5A, -1, 8'h00, 1'b1);
        chk_idle("b2b_after");

        // Backpressure: din changes to FF mid-word while valid stays high
        din       = 8'h0A;
        din_valid = 1'b1;
        tick();
        shift_word(8'h0A, 3, 8'hFF, 1'b0);
        shift_word(8'hFF, -1, 8'h00, 1'b1);
        chk_idle("bp_after");

        // Reset at count 4 of A5
        din       = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_sout", sout, din[7-i]);
            chk("mid_valid", sout_valid, 1'b1);
            if (i == 4) begin
                rst       = 1'b0;
                din_valid = 1'b1;
            end
            tick();
        end
        chk("mrst_sout", sout, 1'b0);
        chk("mrst_valid", sout_valid, 1'b0);
        chk("mrst_ready", din_ready, 1'b0);
        chk("mrst_lsb_valid", sout_valid2, 1'b0);
        din_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("mrst_ready_back", din_ready, 1'b1);
        tick();
        chk_idle("mrst_no_tail");

        din       = 8'h3C;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        shift_word(8'h3C, -1, 8'h00, 1'b1);
        chk_idle("3c_after");

        // Downstream detector on AA
        det_en    = 1'b1;
        din       = 8'hAA;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        shift_word(8'hAA, -1, 8'h00, 1'b1);
        tick();
        det_en = 1'b0;
        checks++;
        assert (pulses === 2) else begin
            errors++;
            $error("FAIL det_pulses observed=%0d expected=2", pulses);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means bit WIDTH-1 is sent first and 0 means bit 0 is sent first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 1'b0, setting the sout level when no word is being shifted.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (sampled only on the rising edge of clk; 0 = reset).
REQ-006 The block SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-007 The block SHALL have port din_valid, input, 1 bit: din holds a word to transfer.
REQ-008 The block SHALL have port din_ready, output, 1 bit: block accepts din in this cycle.
REQ-009 The block SHALL have port sout, output, 1 bit: registered serial bit stream, which is the serial input of the downstream sequence detector.
REQ-010 The block SHALL have port sout_valid, output, 1 bit: sout carries a data bit this cycle.
REQ-011 The block SHALL have port last, output, 1 bit: high during the cycle sout carries the final bit of a word.

Function
REQ-012 A word SHALL transfer when din_valid and din_ready are both 1 at a rising edge of clk (handshake edge H).
REQ-013 The FSM SHALL have two states: IDLE (no word in flight) and SHIFT (word in flight); a bit counter SHALL run 0..WIDTH-1.
REQ-014 In IDLE, din_ready SHALL be 1, sout SHALL equal IDLE_BIT, and sout_valid and last SHALL be 0.
REQ-015 In IDLE, a handshake at edge H SHALL latch din into the shift register, clear the counter to 0, and enter SHIFT.
REQ-016 The first bit SHALL appear on sout in the cycle following H, giving one cycle of latency.
REQ-017 In SHIFT, sout_valid SHALL be 1, and sout SHALL present bit (WIDTH-1-count) when MSB_FIRST=1 or bit (count) when MSB_FIRST=0.
REQ-018 In SHIFT, the counter SHALL increment by 1 on every clock edge; each bit SHALL be held for exactly one cycle.
REQ-019 last SHALL be 1 when count equals WIDTH-1 in SHIFT, and 0 otherwise.
REQ-020 In SHIFT, din_ready SHALL be 1 only when count equals WIDTH-1, and 0 in all other SHIFT cycles.
REQ-021 In SHIFT with count equal to WIDTH-1, a handshake SHALL load the new word and restart the counter at 0, staying in SHIFT, so the next word's first bit follows the previous word's last bit with no gap.
REQ-022 In SHIFT with count equal to WIDTH-1 and no handshake, the FSM SHALL return to IDLE, and sout SHALL return to IDLE_BIT in the next cycle.
REQ-023 din_valid asserted while din_ready is 0 SHALL have no effect, and the word SHALL remain pending on din until accepted.
REQ-024 din SHALL be sampled only at a handshake edge; changes to din mid-word SHALL not affect the bits being shifted.
REQ-025 din_ready SHALL be a combinational function of state and count only, never of din_valid.
REQ-026 sout, sout_valid and last SHALL be driven from registers, with no combinational path from din or din_valid.

Reset
REQ-027 When rst=0 at a rising edge, the block SHALL enter IDLE, clear the counter and shift register to 0, and set sout=IDLE_BIT and sout_valid=0, regardless of state.
REQ-028 A reset mid-word SHALL discard the word in flight, and no remaining bits SHALL be emitted.
REQ-029 While rst=0, din_ready SHALL be 0 and no handshake SHALL occur, even if din_valid=1.
REQ-030 The block SHALL have no asynchronous behaviour; reset asserted between edges SHALL take effect only at the next rising edge.

Verification
REQ-031 Single word: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at edge H -> on cycles H+1..H+8, sout=1,0,1,0,0,1,0,1 and sout_valid=1; last=1 only at H+8; sout=IDLE_BIT at H+9.
REQ-032 Back-to-back: din=8'hA0, then 8'h5A presented while din_ready rises at count 7 -> 16 consecutive valid bits 10100000 01011010, with no idle cycle between words.
REQ-033 Backpressure: din_valid held at 1 with din changed to 8'hFF at count 3 of word 8'h0A -> word 8'h0A is emitted unaltered, and 8'hFF is accepted only at the count-7 edge.
REQ-034 LSB-first: MSB_FIRST=0, din=8'h0A -> sout=0,1,0,1,0,0,0,0.
REQ-035 Reset mid-word: rst=0 for one edge at count 4 of 8'hA5 -> the next cycle shows sout=IDLE_BIT, sout_valid=0 and din_ready=0; after rst returns to 1, din_ready=1 and a new word 8'h3C is emitted correctly.
REQ-036 Downstream check: stream 8'hAA into the sequence detector -> the detector output pulses exactly twice, confirming bit order and timing.
